// File: rtl/mem_access_pkg.sv
// Shared types and byte-lane helpers for the data-memory access controller.
// Lanes are little-endian and hard-wired for a 32-bit data path.
package mem_access_pkg;

  localparam int LANE_W    = 8;
  localparam int HALF_W    = 16;
  localparam int WORD_W    = 32;
  localparam int NUM_LANES = WORD_W / LANE_W;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10
  } size_e;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RD    = 3'd1,
    MERGE = 3'd2,
    WR    = 3'd3,
    RESP  = 3'd4
  } state_e;

  // The reserved encoding 2'b11 behaves as a word access.
  function automatic size_e decode_size(input logic [1:0] raw);
    size_e sz;
    case (raw)
      2'b00:   sz = SZ_BYTE;
      2'b01:   sz = SZ_HALF;
      default: sz = SZ_WORD;
    endcase
    return sz;
  endfunction

  function automatic logic is_misaligned(input size_e size, input logic [1:0] addr_lo);
    logic bad;
    case (size)
      SZ_HALF: bad = addr_lo[0];
      SZ_WORD: bad = (addr_lo != 2'b00);
      default: bad = 1'b0;
    endcase
    return bad;
  endfunction

  function automatic logic [WORD_W-1:0] lane_extract(
    input logic [WORD_W-1:0] word,
    input logic [1:0]        addr_lo,
    input size_e             size,
    input logic              sign
  );
    logic [LANE_W-1:0] byte_v;
    logic [HALF_W-1:0] half_v;
    logic [WORD_W-1:0] res;
    byte_v = word[{addr_lo, 3'b000} +: LANE_W];
    half_v = word[{addr_lo[1], 4'b0000} +: HALF_W];
    case (size)
      SZ_BYTE: res = {{(WORD_W-LANE_W){sign & byte_v[LANE_W-1]}}, byte_v};
      SZ_HALF: res = {{(WORD_W-HALF_W){sign & half_v[HALF_W-1]}}, half_v};
      default: res = word;
    endcase
    return res;
  endfunction

  // Replace only the addressed lanes; the store data is replicated across
  // lanes so each lane just picks old or new by its enable bit.
  function automatic logic [WORD_W-1:0] lane_merge(
    input logic [WORD_W-1:0] word,
    input logic [WORD_W-1:0] wdata,
    input logic [1:0]        addr_lo,
    input size_e             size
  );
    logic [NUM_LANES-1:0] be;
    logic [WORD_W-1:0]    rep;
    logic [WORD_W-1:0]    res;
    case (size)
      SZ_BYTE: begin
        be  = 4'b0001 << addr_lo;
        rep = {NUM_LANES{wdata[LANE_W-1:0]}};
      end
      SZ_HALF: begin
        be  = addr_lo[1] ? 4'b1100 : 4'b0011;
        rep = {2{wdata[HALF_W-1:0]}};
      end
      default: begin
        be  = 4'b1111;
        rep = wdata;
      end
    endcase
    for (int i = 0; i < NUM_LANES; i++) begin
      res[i*LANE_W +: LANE_W] = be[i] ? rep[i*LANE_W +: LANE_W] : word[i*LANE_W +: LANE_W];
    end
    return res;
  endfunction

endpackage

// File: rtl/byte_lane_unit.sv
// Combinational lane logic: extends load data and merges sub-word store data
// into the word read back from memory.
module byte_lane_unit
  import mem_access_pkg::*;
(
  input  logic [WORD_W-1:0] rd_word_i,
  input  logic [WORD_W-1:0] wdata_i,
  input  logic [1:0]        addr_lo_i,
  input  size_e             size_i,
  input  logic              sign_i,
  output logic [WORD_W-1:0] load_data_o,
  output logic [WORD_W-1:0] merged_o
);

  assign load_data_o = lane_extract(rd_word_i, addr_lo_i, size_i, sign_i);
  assign merged_o    = lane_merge(rd_word_i, wdata_i, addr_lo_i, size_i);

endmodule

// File: rtl/mem_access_ctrl.sv
// Load/store initiator for dataMem: word-wide cycles with read-modify-write for
// sub-word stores. Define MEM_ACCESS_MISALIGN_ABORT_EN to abort misaligned accesses.
module mem_access_ctrl
  import mem_access_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_error,
  output logic [ADDR_W-1:0] mem_A,
  output logic [DATA_W-1:0] mem_WD,
  output logic              mem_OE,
  output logic              mem_wEnable,
  input  logic [DATA_W-1:0] mem_RD
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  size_e             size_q, size_d;
  logic              sign_q, sign_d;
  logic              write_q, write_d;
  logic              err_q, err_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] wword_q, wword_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;

  size_e             req_size_dec;
  logic              abort_req;
  logic [DATA_W-1:0] load_data;
  logic [DATA_W-1:0] merged;

  assign req_size_dec = decode_size(req_size);

`ifdef MEM_ACCESS_MISALIGN_ABORT_EN
  assign abort_req = is_misaligned(req_size_dec, req_addr[1:0]);
`else
  assign abort_req = 1'b0;
`endif

  byte_lane_unit u_lanes (
    .rd_word_i   (mem_RD),
    .wdata_i     (wdata_q),
    .addr_lo_i   (addr_q[1:0]),
    .size_i      (size_q),
    .sign_i      (sign_q),
    .load_data_o (load_data),
    .merged_o    (merged)
  );

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    size_d  = size_q;
    sign_d  = sign_q;
    write_d = write_q;
    err_d   = err_q;
    wdata_d = wdata_q;
    wword_d = wword_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          addr_d  = req_addr;
          size_d  = req_size_dec;
          sign_d  = req_signed;
          write_d = req_write;
          wdata_d = req_wdata;
          err_d   = abort_req;
          rdata_d = '0;
          if (abort_req) begin
            state_d = RESP;
          end else if (req_write && (req_size_dec == SZ_WORD)) begin
            state_d = WR;
          end else begin
            state_d = RD;
          end
        end
      end
      RD: state_d = MERGE;
      // mem_RD now carries the word addressed during RD.
      MERGE: begin
        rdata_d = write_q ? '0 : load_data;
        wword_d = merged;
        state_d = write_q ? WR : RESP;
      end
      WR:      state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      size_q  <= SZ_BYTE;
      sign_q  <= 1'b0;
      write_q <= 1'b0;
      err_q   <= 1'b0;
      wdata_q <= '0;
      wword_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      size_q  <= size_d;
      sign_q  <= sign_d;
      write_q <= write_d;
      err_q   <= err_d;
      wdata_q <= wdata_d;
      wword_q <= wword_d;
      rdata_q <= rdata_d;
    end
  end

  // Every memory strobe decodes from state_q, so reset cancels a pending write at once.
  assign req_ready   = (state_q == IDLE);
  assign resp_valid  = (state_q == RESP);
  assign resp_rdata  = (state_q == RESP) ? rdata_q : '0;
  assign resp_error  = (state_q == RESP) && err_q;
  assign mem_A       = (state_q == IDLE) ? '0 : {addr_q[ADDR_W-1:2], 2'b00};
  assign mem_OE      = (state_q == RD);
  assign mem_wEnable = (state_q == WR);
  assign mem_WD      = (state_q != WR)     ? '0 :
                       (size_q == SZ_WORD) ? wdata_q : wword_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Randomized self-checking bench for mem_access_ctrl paired with a dataMem model.
`timescale 1ns/1ps
module tb_mem_access_ctrl;

  localparam int NWORDS = 64;

  logic        clock = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_write, req_signed;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_error;
  logic [31:0] resp_rdata;
  logic [31:0] mem_A, mem_WD, mem_RD;
  logic        mem_OE, mem_wEnable;

  int checks = 0;
  int passes = 0;

  always #5 clock = ~clock;

  mem_access_ctrl #(.ADDR_W(32), .DATA_W(32)) dut (
    .clock       (clock),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_write   (req_write),
    .req_size    (req_size),
    .req_signed  (req_signed),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .resp_valid  (resp_valid),
    .resp_rdata  (resp_rdata),
    .resp_error  (resp_error),
    .mem_A       (mem_A),
    .mem_WD      (mem_WD),
    .mem_OE      (mem_OE),
    .mem_wEnable (mem_wEnable),
    .mem_RD      (mem_RD)
  );

  // dataMem: synchronous write, read data registered one clock after OE.
  logic [31:0] dmem [NWORDS];
  always @(posedge clock) begin
    if (mem_wEnable) dmem[mem_A[7:2]] <= mem_WD;
    if (mem_OE) mem_RD <= dmem[mem_A[7:2]];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
  endtask

  // Reference model: architectural memory plus ARM load/store rules.
  logic [31:0] ref_mem [NWORDS];

  function automatic logic [31:0] mdl_load(input logic [31:0] w, input int a, input int sz, input bit sg);
    longint v;
    if (sz == 0) begin
      v = (longint'(w) >> (8 * (a % 4))) & 255;
      if (sg && v >= 128) v = v - 256;
    end else if (sz == 1) begin
      v = (longint'(w) >> (16 * ((a / 2) % 2))) & 65535;
      if (sg && v >= 32768) v = v - 65536;
    end else begin
      v = longint'(w);
    end
    return v[31:0];
  endfunction

  function automatic logic [31:0] mdl_store(input logic [31:0] w, input logic [31:0] wd, input int a, input int sz);
    logic [31:0] mask, ins;
    int sh;
    if (sz == 0) begin
      sh   = 8 * (a % 4);
      mask = 32'hFF << sh;
      ins  = (wd & 32'hFF) << sh;
    end else if (sz == 1) begin
      sh   = 16 * ((a / 2) % 2);
      mask = 32'hFFFF << sh;
      ins  = (wd & 32'hFFFF) << sh;
    end else begin
      return wd;
    end
    return (w & ~mask) | ins;
  endfunction

  bit          m_busy = 1'b0;
  bit          m_write, m_abort, m_we;
  int          m_k, m_lat, m_size;
  logic [31:0] m_addr, m_rdata, m_wword;
  logic [5:0]  m_widx;

  // Per-cycle compare against the model's expected transaction timeline.
  initial begin
    forever begin
      @(negedge clock);
      if (reset) begin
        m_busy = 1'b0;
        chk1("rst_req_ready", req_ready, 1'b1);
        chk1("rst_resp_valid", resp_valid, 1'b0);
        chk1("rst_resp_error", resp_error, 1'b0);
        chk("rst_resp_rdata", resp_rdata, 32'h0);
        chk("rst_mem_A", mem_A, 32'h0);
        chk("rst_mem_WD", mem_WD, 32'h0);
        chk1("rst_mem_OE", mem_OE, 1'b0);
        chk1("rst_mem_wEnable", mem_wEnable, 1'b0);
      end else if (!m_busy) begin
        chk1("idle_req_ready", req_ready, 1'b1);
        chk1("idle_resp_valid", resp_valid, 1'b0);
        chk1("idle_mem_OE", mem_OE, 1'b0);
        chk1("idle_mem_wEnable", mem_wEnable, 1'b0);
        chk("idle_mem_A", mem_A, 32'h0);
        chk("idle_mem_WD", mem_WD, 32'h0);
        if (req_valid) begin
          m_write = req_write;
          m_size  = (req_size == 2'b11) ? 2 : int'(req_size);
          m_addr  = req_addr;
          m_abort = 1'b0;
`ifdef MEM_ACCESS_MISALIGN_ABORT_EN
          m_abort = (m_size == 1 && (m_addr % 2) != 0) || (m_size == 2 && (m_addr % 4) != 0);
`endif
          m_widx  = m_addr[7:2];
          m_rdata = 32'h0;
          m_wword = 32'h0;
          if (m_abort) begin
            m_lat = 1;
          end else if (m_write) begin
            m_lat   = (m_size == 2) ? 2 : 4;
            m_wword = mdl_store(ref_mem[m_widx], req_wdata, int'(m_addr), m_size);
          end else begin
            m_lat   = 3;
            m_rdata = mdl_load(ref_mem[m_widx], int'(m_addr), m_size, req_signed);
          end
          m_busy = 1'b1;
          m_k    = 0;
        end
      end else begin
        m_k++;
        m_we = m_write && !m_abort && (m_k == ((m_size == 2) ? 1 : 3));
        chk1("busy_req_ready", req_ready, 1'b0);
        chk1("resp_valid", resp_valid, m_k == m_lat);
        chk1("mem_OE", mem_OE, !m_abort && !(m_write && m_size == 2) && m_k == 1);
        chk1("mem_wEnable", mem_wEnable, m_we);
        chk("mem_A", mem_A, m_addr - (m_addr % 4));
        chk("mem_WD", mem_WD, m_we ? m_wword : 32'h0);
        if (m_k == m_lat) begin
          chk("resp_rdata", resp_rdata, m_rdata);
          chk1("resp_error", resp_error, m_abort);
          if (m_write && !m_abort) ref_mem[m_widx] = m_wword;
          m_busy = 1'b0;
        end
      end
    end
  end

  int txn = 0;

  // Offers one request in an idle cycle; returns response data and the cycle
  // index (acceptance = 0) at which resp_valid was seen.
  task automatic do_req(input bit w, input logic [1:0] sz, input bit sg,
                        input logic [31:0] a, input logic [31:0] wd,
                        output logic [31:0] rd, output bit er, output int lat);
    req_valid  = 1'b1;
    req_write  = w;
    req_size   = sz;
    req_signed = sg;
    req_addr   = a;
    req_wdata  = wd;
    @(posedge clock); #1;
    req_valid  = 1'b0;
    req_write  = $urandom_range(0, 1) == 1;
    req_size   = 2'($urandom_range(0, 3));
    req_signed = $urandom_range(0, 1) == 1;
    req_addr   = $urandom;
    req_wdata  = $urandom;
    lat = 1;
    while (!resp_valid && lat < 12) begin
      @(posedge clock); #1;
      lat++;
    end
    chk1("resp_seen", resp_valid, 1'b1);
    rd = resp_rdata;
    er = resp_error;
    $display("txn %0d: %s size=%0d signed=%0d addr=%h wdata=%h -> rdata=%h err=%0d lat=%0d",
             txn, w ? "ST" : "LD", sz, sg, a, wd, rd, er, lat);
    txn++;
    @(posedge clock); #1;
  endtask

  initial begin
    logic [31:0] rd;
    bit          er;
    int          lat;
    reset      = 1'b1;
    req_valid  = 1'b0;
    req_write  = 1'b0;
    req_size   = 2'b00;
    req_signed = 1'b0;
    req_addr   = 32'h0;
    req_wdata  = 32'h0;
    repeat (3) @(posedge clock);
    #1;
    chk1("reset_req_ready", req_ready, 1'b1);
    chk("reset_mem_A", mem_A, 32'h0);
    reset = 1'b0;
    @(posedge clock); #1;

    for (int i = 0; i < NWORDS; i++) do_req(1'b1, 2'b10, 1'b0, 32'(i * 4), $urandom, rd, er, lat);

    do_req(1'b1, 2'b10, 1'b0, 32'h0, 32'h0000_0002, rd, er, lat);
    chk("word_store_latency", lat, 2);
    do_req(1'b0, 2'b10, 1'b0, 32'h0, 32'h0, rd, er, lat);
    chk("word_load_latency", lat, 3);
    chk("word_load_data", rd, 32'h0000_0002);

    do_req(1'b1, 2'b10, 1'b0, 32'h4, 32'h1122_3344, rd, er, lat);
    do_req(1'b1, 2'b00, 1'b0, 32'h6, 32'h0000_00AA, rd, er, lat);
    chk("byte_store_latency", lat, 4);
    do_req(1'b0, 2'b10, 1'b0, 32'h4, 32'h0, rd, er, lat);
    chk("byte_rmw_result", rd, 32'h11AA_3344);

    do_req(1'b1, 2'b10, 1'b0, 32'h8, 32'h80F0_7F01, rd, er, lat);
    do_req(1'b0, 2'b00, 1'b1, 32'h9, 32'h0, rd, er, lat);
    chk("ldrsb_0x9", rd, 32'h0000_007F);
    do_req(1'b0, 2'b00, 1'b1, 32'hA, 32'h0, rd, er, lat);
    chk("ldrsb_0xA", rd, 32'hFFFF_FFF0);
    do_req(1'b0, 2'b01, 1'b0, 32'hA, 32'h0, rd, er, lat);
    chk("ldrh_0xA", rd, 32'h0000_80F0);
    do_req(1'b0, 2'b01, 1'b1, 32'hA, 32'h0, rd, er, lat);
    chk("ldrsh_0xA", rd, 32'hFFFF_80F0);

    // Reset while the byte store to 0x4 sits in MERGE.
    req_valid = 1'b1; req_write = 1'b1; req_size = 2'b00; req_signed = 1'b0;
    req_addr  = 32'h4; req_wdata = 32'h55;
    @(posedge clock); #1;
    req_valid = 1'b0;
    @(posedge clock); #1;
    reset = 1'b1;
    #1;
    chk1("midrst_mem_wEnable", mem_wEnable, 1'b0);
    chk1("midrst_mem_OE", mem_OE, 1'b0);
    chk("midrst_mem_A", mem_A, 32'h0);
    chk1("midrst_req_ready", req_ready, 1'b1);
    @(posedge clock); #1;
    @(posedge clock); #1;
    reset = 1'b0;
    @(posedge clock); #1;
    chk("midrst_word_kept", dmem[1], 32'h11AA_3344);
    do_req(1'b0, 2'b10, 1'b0, 32'h4, 32'h0, rd, er, lat);
    chk("midrst_load_0x4", rd, 32'h11AA_3344);

    do_req(1'b1, 2'b10, 1'b0, 32'hC, 32'h1234_5678, rd, er, lat);
    do_req(1'b1, 2'b01, 1'b0, 32'hC, 32'h0000_BEEF, rd, er, lat);
    chk1("b2b_ready", req_ready, 1'b1);
    do_req(1'b0, 2'b10, 1'b0, 32'hC, 32'h0, rd, er, lat);
    chk("b2b_load_0xC", rd, 32'h1234_BEEF);

    do_req(1'b0, 2'b10, 1'b0, 32'h2, 32'h0, rd, er, lat);
`ifdef MEM_ACCESS_MISALIGN_ABORT_EN
    chk("misalign_latency", lat, 1);
    chk1("misalign_error", er, 1'b1);
    chk("misalign_rdata", rd, 32'h0);
`else
    chk("misalign_latency", lat, 3);
    chk1("misalign_error", er, 1'b0);
    chk("misalign_rdata", rd, 32'h0000_0002);
`endif

    for (int i = 0; i < 300; i++) begin
      do_req($urandom_range(0, 1) == 1, 2'($urandom_range(0, 3)), $urandom_range(0, 1) == 1,
             32'($urandom_range(0, 255)), $urandom, rd, er, lat);
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clock); #1;
      end
    end

    for (int i = 0; i < NWORDS; i++) chk("final_mem_word", dmem[i], ref_mem[i]);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
Initiator side of the data-memory port in the ARMv4 minimal computer. It sits between the core's load/store stage and dataMem, and drives dataMem's A, WD, OE and wEnable pins and consumes its RD pin. It turns byte, halfword and word loads/stores into word-wide memory cycles, with read-modify-write for sub-word stores. Loads are sign- or zero-extended per ARMv4 LDR/LDRB/LDRH/LDRSB/LDRSH.

Parameters:
ADDR_W, 32, request and memory address width
DATA_W, 32, data width; only 32 is supported, because four byte lanes are hard-wired

Ports:
clock  in  1  system clock; all state updates on the rising edge
reset  in  1  asynchronous, active-high reset
req_valid  in  1  core presents a request
req_ready  out  1  controller can accept a request; high only in IDLE
req_write  in  1  1 = store, 0 = load
req_size  in  2  00 byte, 01 halfword, 10 word, 11 reserved (treated as word)
req_signed  in  1  sign-extend sub-word loads; ignored for stores and word loads
req_addr  in  ADDR_W  byte address
req_wdata  in  DATA_W  store data, right-justified
resp_valid  out  1  one-cycle completion pulse
resp_rdata  out  DATA_W  extended load data; 0 for stores
resp_error  out  1  misaligned abort (only with the optional feature)
mem_A  out  ADDR_W  to dataMem A; word-aligned address
mem_WD  out  DATA_W  to dataMem WD
mem_OE  out  1  to dataMem OE
mem_wEnable  out  1  to dataMem wEnable; dataMem writes on the clock edge while high
mem_RD  in  DATA_W  from dataMem RD; valid one clock after mem_A/mem_OE are presented

Behaviour:
- Reset is asynchronous and active-high.
  - It forces IDLE.
  - It forces req_ready=1 and clears resp_valid, resp_rdata, resp_error, mem_A, mem_WD, mem_OE and mem_wEnable to 0.
  - All mem_* outputs decode from the state register, so a reset mid-operation kills any pending write immediately. No partial RMW write is issued afterwards.
- State machine states: IDLE, RD, MERGE, WR, RESP.
- Acceptance: a request is accepted when req_valid && req_ready in IDLE. On acceptance, addr, size, signed and wdata are latched and held until RESP completes.
- State transitions:
  - IDLE -> WR for a word store.
  - IDLE -> RD for a load or a sub-word store.
  - RD -> MERGE.
  - MERGE -> RESP for a load; MERGE -> WR for a sub-word store.
  - WR -> RESP.
  - RESP -> IDLE.
- Memory outputs per state:
  - RD: mem_OE=1 and mem_A={addr[ADDR_W-1:2],2'b00}.
  - MERGE: mem_RD is sampled.
  - WR: mem_wEnable=1, mem_OE=0, and mem_WD = the store word (word store) or the merged word (sub-word store).
  - mem_A holds the aligned address in every non-IDLE state and is 0 in IDLE.
  - mem_WD is 0 outside WR.
- Latency from the acceptance cycle (cycle 0) to the resp_valid cycle:
  - word store: 2
  - load: 3
  - byte or halfword store: 4
- Response:
  - resp_valid, resp_rdata and resp_error are registered and high only in RESP, for exactly one cycle.
  - The next request can be accepted in the cycle after RESP.
- Byte lanes are little-endian.
  - Byte k = addr[1:0] occupies bits [8k+7:8k].
  - A halfword at addr[1] occupies bits [16*addr[1]+15:16*addr[1]].
- Loads:
  - The selected lane is shifted to bit 0.
  - It is sign-extended if req_signed, otherwise zero-extended.
- Sub-word stores:
  - Only the addressed lane(s) of the word read in MERGE are replaced with req_wdata[7:0] / [15:0].
  - All other lanes are preserved bit-exactly.
- Misalignment without the optional feature:
  - Word accesses ignore addr[1:0].
  - Halfword accesses ignore addr[0].
- Input changes: req_* changes while not in IDLE are ignored.
- Back-to-back requests: the second request always observes the first one's write, because the write completes before RESP.

Optional Feature:
MEM_ACCESS_MISALIGN_ABORT_EN
- Defined: a halfword request with addr[0]=1, or a word request with addr[1:0]!=0, goes IDLE -> RESP. In that case:
  - no memory cycle is issued (mem_OE = mem_wEnable = 0 throughout);
  - resp_error=1 and resp_rdata=0 for one cycle.
- Undefined: resp_error is tied to 0 and the lane behaviour above applies.

Decomposition:
- Package mem_access_pkg holds:
  - size_e (SZ_BYTE, SZ_HALF, SZ_WORD);
  - state_e;
  - lane-width constants;
  - functions lane_extract(word, addr_lo, size, signed) and lane_merge(word, wdata, addr_lo, size).
- One combinational sub-module, byte_lane_unit, wraps extract and merge.
- The FSM, latches and outputs stay in mem_access_ctrl.
- The bench pairs the DUT with dataMem as the memory model.

Test Plan:
- Word store then word load: store 0x0000_0002 at 0x0 -> mem_wEnable in cycle 1, resp_valid in cycle 2. Load of 0x0 -> resp_rdata=0x0000_0002 in cycle 3.
- Byte RMW: word 0x4 = 0x1122_3344; store byte 0xAA at 0x6 -> one mem_OE cycle, then one write of 0x11AA_3344, resp_valid in cycle 4.
- Signed and unsigned sub-word loads: word 0x8 = 0x80F0_7F01.
  - LDRSB 0x9 -> 0x0000_007F.
  - LDRSB 0xA -> 0xFFFF_FFF0.
  - LDRH 0xA -> 0x0000_80F0.
  - LDRSH 0xA -> 0xFFFF_80F0.
- Reset mid-RMW: assert reset during MERGE of a byte store to 0x4 -> mem_wEnable never rises, outputs 0 immediately, word 0x4 unchanged, req_ready=1.
- Back-to-back: a halfword store 0xBEEF at 0xC is followed by a load of 0xC offered on the cycle after RESP. The load is accepted in that cycle and returns 0x????_BEEF (upper half preserved).
- Misaligned word load at 0x2:
  - with MEM_ACCESS_MISALIGN_ABORT_EN: resp_error=1 in cycle 1, no mem_OE.
  - without: the word at 0x0 is returned in cycle 3.
